// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and encodings for the framebuffer arbiter: pixel width,
// default frame geometry, RAM grant encoding and display fetch states.
package vga_fb_pkg;

  localparam int RGB_W        = 12;
  localparam int FB_WORDS_DEF = 49152;
  localparam int ADDR_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } grant_e;

  typedef enum logic {
    FS_DONE = 1'b0,
    FS_RUN  = 1'b1
  } fetch_st_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-writer handshake and single-port framebuffer RAM bus. The slave view
// belongs to the arbiter; the master view to the writer and RAM around it.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [11:0]       ram_wdata;
  logic [11:0]       ram_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data, ram_rdata,
    output wr_ready, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data, ram_rdata,
    input  wr_ready, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter_fifo.sv
// Show-ahead display FIFO: the head word is always on rdata, and rdata is
// forced to zero while the FIFO is empty. Flush wins over push and pop.
module fb_disp_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 12,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_vga,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] occ,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (cnt_q == '0);
  assign occ   = cnt_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && (cnt_q != CNT_W'(DEPTH));
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is readable.
  always_ff @(posedge clk_vga) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between raster-order display
// prefetch (into fb_disp_fifo) and a pixel writer, all in clk_vga.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int FB_WORDS = FB_WORDS_DEF,
  parameter int DEPTH    = 16,
  parameter int LOW_WM   = 4
) (
  input  logic              clk_vga,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              disp_rd,
  output logic [RGB_W-1:0]  disp_data,
  output logic [7:0]        underflow_cnt,
  vga_fb_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_st_e         st_q, st_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [RGB_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic              rd2_q, rd2_d;
  logic              stale2_q, stale2_d;
  logic [7:0]        ufl_q, ufl_d;

  grant_e            grant;
  logic              wr_ready_c;
  logic              rd1;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W-1:0]  credits;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  // Stage 1 is the registered read strobe, stage 2 the cycle its data returns.
  assign rd1     = ram_en_q && !ram_we_q;
  assign credits = occ + CNT_W'(rd1) + CNT_W'(rd2_q);

  assign push = rd2_q && !stale2_q && !frame_start;
  assign pop  = disp_rd && !frame_start && !fifo_empty;

  fb_disp_fifo #(
    .DEPTH (DEPTH),
    .W     (RGB_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_vga (clk_vga),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (frame_start),
    .wdata   (bus.ram_rdata),
    .rdata   (disp_data),
    .occ     (occ),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      st_q         <= FS_DONE;
      fetch_addr_q <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rd2_q        <= 1'b0;
      stale2_q     <= 1'b0;
      ufl_q        <= '0;
    end else begin
      st_q         <= st_d;
      fetch_addr_q <= fetch_addr_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rd2_q        <= rd2_d;
      stale2_q     <= stale2_d;
      ufl_q        <= ufl_d;
    end
  end

  // Grant decision: urgent display fetch, else writer, else opportunistic fetch.
  always_comb begin
    grant      = IDLE;
    wr_ready_c = 1'b1;
    if (!frame_start && (st_q == FS_RUN) && (credits < CNT_W'(LOW_WM))) begin
      grant      = FETCH;
      wr_ready_c = 1'b0;
    end else if (bus.wr_valid) begin
      grant = WRITE;
    end else if (!frame_start && (st_q == FS_RUN) && (credits < CNT_W'(DEPTH))) begin
      grant = FETCH;
    end
  end

  always_comb begin
    st_d         = st_q;
    fetch_addr_d = fetch_addr_q;
    ram_en_d     = (grant != IDLE);
    ram_we_d     = (grant == WRITE);
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ufl_d        = ufl_q;

    case (grant)
      FETCH: begin
        ram_addr_d   = fetch_addr_q;
        fetch_addr_d = fetch_addr_q + ADDR_W'(1);
        if (fetch_addr_q == ADDR_W'(FB_WORDS - 1)) begin
          st_d = FS_DONE;
        end
      end
      WRITE: begin
        ram_addr_d  = bus.wr_addr;
        ram_wdata_d = bus.wr_data;
      end
      default: ;
    endcase

    if (frame_start) begin
      st_d         = FS_RUN;
      fetch_addr_d = '0;
    end

    // A read still in stage 1 at a restart belongs to the old frame.
    rd2_d    = rd1;
    stale2_d = rd1 && frame_start;

    if (disp_rd && !frame_start && fifo_empty && (ufl_q != 8'hFF)) begin
      ufl_d = ufl_q + 8'd1;
    end
  end

  assign bus.wr_ready   = wr_ready_c;
  assign bus.ram_en     = ram_en_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign underflow_cnt  = ufl_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: a vector table for the grant and pop
// rules, then hand sequences for fill, streaming, writes, restart and reset.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs, rd, fs8;
  logic [11:0] disp_data, disp_data8;
  logic [7:0]  ufl, ufl8;
  logic [11:0] ram_xor;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(16)) bus ();
  vga_fb_arbiter_if #(.ADDR_W(16)) bus8 ();

  vga_fb_arbiter dut (
    .clk_vga       (clk),
    .rst           (rst),
    .frame_start   (fs),
    .disp_rd       (rd),
    .disp_data     (disp_data),
    .underflow_cnt (ufl),
    .bus           (bus)
  );

  vga_fb_arbiter #(.FB_WORDS(8)) dut8 (
    .clk_vga       (clk),
    .rst           (rst),
    .frame_start   (fs8),
    .disp_rd       (1'b0),
    .disp_data     (disp_data8),
    .underflow_cnt (ufl8),
    .bus           (bus8)
  );

  // RAM models: read word = low address bits xor a per-test pattern.
  always @(posedge clk) begin
    if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= bus.ram_addr[11:0] ^ ram_xor;
    if (bus8.ram_en && !bus8.ram_we) bus8.ram_rdata <= bus8.ram_addr[11:0];
  end

  typedef struct {
    logic        fs;
    logic        rd;
    logic        wv;
    logic        exp_rdy;
    logic [11:0] exp_data;
    logic        exp_en;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_ufl;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    fs            = 1'b0;
    fs8           = 1'b0;
    rd            = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus8.wr_valid = 1'b0;
    bus8.wr_addr  = '0;
    bus8.wr_data  = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  initial begin
    int  nrd, first_c, wa, wd, nwr;
    logic hs, found;
    logic [11:0] exp;

    ram_xor       = 12'h000;
    bus.ram_rdata = '0;
    bus8.ram_rdata = '0;

    //       fs   rd   wv  rdy  data     en   we   addr      ufl
    vt[0]  = '{1'b0,1'b1,1'b0,1'b1,12'h000,1'b0,1'b0,16'h0000,8'd1};
    vt[1]  = '{1'b0,1'b1,1'b0,1'b1,12'h000,1'b0,1'b0,16'h0000,8'd2};
    vt[2]  = '{1'b0,1'b1,1'b1,1'b1,12'h000,1'b1,1'b1,16'h0123,8'd3};
    vt[3]  = '{1'b1,1'b1,1'b0,1'b1,12'h000,1'b0,1'b0,16'h0000,8'd3};
    vt[4]  = '{1'b0,1'b0,1'b1,1'b0,12'h000,1'b1,1'b0,16'h0000,8'd3};
    vt[5]  = '{1'b0,1'b0,1'b1,1'b0,12'h000,1'b1,1'b0,16'h0001,8'd3};
    vt[6]  = '{1'b0,1'b0,1'b1,1'b0,12'h000,1'b1,1'b0,16'h0002,8'd3};
    vt[7]  = '{1'b0,1'b0,1'b1,1'b0,12'h800,1'b1,1'b0,16'h0003,8'd3};
    vt[8]  = '{1'b0,1'b0,1'b1,1'b1,12'h800,1'b1,1'b1,16'h0123,8'd3};
    vt[9]  = '{1'b0,1'b0,1'b1,1'b1,12'h800,1'b1,1'b1,16'h0123,8'd3};
    vt[10] = '{1'b0,1'b0,1'b1,1'b1,12'h800,1'b1,1'b1,16'h0123,8'd3};
    vt[11] = '{1'b0,1'b1,1'b0,1'b1,12'h800,1'b1,1'b0,16'h0004,8'd3};
    vt[12] = '{1'b0,1'b1,1'b0,1'b1,12'h801,1'b1,1'b0,16'h0005,8'd3};
    vt[13] = '{1'b0,1'b1,1'b0,1'b1,12'h802,1'b1,1'b0,16'h0006,8'd3};

    // Reset values
    do_reset();
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_ufl", ufl, 0);
    chk("rst_data", disp_data, 0);
    repeat (3) tick();
    chk("done_no_fetch", bus.ram_en, 0);

    // Vector table
    do_reset();
    ram_xor     = 12'h800;
    bus.wr_addr = 16'h0123;
    bus.wr_data = 12'hABC;
    for (int i = 0; i < 14; i++) begin
      fs = vt[i].fs;
      rd = vt[i].rd;
      bus.wr_valid = vt[i].wv;
      #1;
      chk($sformatf("vec%0d_wr_ready", i), bus.wr_ready, vt[i].exp_rdy);
      chk($sformatf("vec%0d_disp_data", i), disp_data, vt[i].exp_data);
      tick();
      chk($sformatf("vec%0d_ram_en", i), bus.ram_en, vt[i].exp_en);
      chk($sformatf("vec%0d_ufl", i), ufl, vt[i].exp_ufl);
      if (vt[i].exp_en) begin
        chk($sformatf("vec%0d_ram_we", i), bus.ram_we, vt[i].exp_we);
        chk($sformatf("vec%0d_ram_addr", i), bus.ram_addr, vt[i].exp_addr);
        if (vt[i].exp_we) chk($sformatf("vec%0d_wdata", i), bus.ram_wdata, 12'hABC);
      end
    end
    fs = 1'b0; rd = 1'b0; bus.wr_valid = 1'b0;

    // First-pixel latency: three edges after the one that takes frame_start
    do_reset();
    ram_xor = 12'hA5A;
    pulse_fs();
    tick();
    tick();
    chk("lat_before", disp_data, 12'h000);
    tick();
    chk("lat_first", disp_data, 12'hA5A);

    // Fill: 16 back-to-back reads of 0..15, then the RAM goes quiet
    do_reset();
    ram_xor = 12'h000;
    pulse_fs();
    nrd = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      chk($sformatf("fill_en_c%0d", c), bus.ram_en, (c <= 16) ? 1 : 0);
      if (bus.ram_en) begin
        chk("fill_we", bus.ram_we, 0);
        chk("fill_addr", bus.ram_addr, nrd);
        nrd++;
      end
    end
    chk("fill_reads", nrd, 16);
    chk("fill_head", disp_data, 12'h000);

    // Streaming pops from cycle 20, optionally with a writer that never lets go
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      ram_xor = 12'h000;
      exp = 12'h000;
      wa  = 16'hC000;
      wd  = 12'h5A0;
      nwr = 0;
      for (int c = 0; c < 1020; c++) begin
        fs = (c == 0);
        rd = (c >= 20);
        bus.wr_valid = (pass == 1);
        bus.wr_addr  = wa[15:0];
        bus.wr_data  = wd[11:0];
        #1;
        hs = bus.wr_valid && bus.wr_ready;
        if (pass == 1 && c <= 5) begin
          chk($sformatf("wr_ready_c%0d", c), bus.wr_ready, (c >= 1 && c <= 4) ? 0 : 1);
        end
        if (rd) begin
          chk("stream_data", disp_data, exp);
          exp = exp + 12'd1;
        end
        tick();
        if (hs) begin
          chk("wr_strobe", {bus.ram_en, bus.ram_we}, 3);
          chk("wr_addr", bus.ram_addr, wa);
          chk("wr_data", bus.ram_wdata, wd);
          wa++;
          wd = (wd + 1) & 12'hFFF;
          nwr++;
        end else if (pass == 1) begin
          chk("wr_none", bus.ram_en && bus.ram_we, 0);
        end
      end
      fs = 1'b0; rd = 1'b0; bus.wr_valid = 1'b0;
      chk($sformatf("stream%0d_last", pass), exp, 12'h3E8);
      chk($sformatf("stream%0d_ufl", pass), ufl, 0);
      if (pass == 1) chk("wr_some", (nwr > 0) ? 1 : 0, 1);
    end

    // Underflow counting and saturation before any frame
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rd = 1'b1;
      #1;
      if (i < 3) chk("ufl_data", disp_data, 0);
      tick();
      if (i == 2) chk("ufl_3", ufl, 3);
    end
    rd = 1'b0;
    chk("ufl_sat", ufl, 255);

    // Restart while reads of 5 and 6 are in flight
    do_reset();
    ram_xor = 12'h300;
    pulse_fs();
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      tick();
      if (bus.ram_en && !bus.ram_we && bus.ram_addr == 16'd6) found = 1'b1;
    end
    chk("restart_found", found, 1);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    first_c = -1;
    for (int c = 0; c < 30; c++) begin
      if (first_c < 0 && bus.ram_en && !bus.ram_we) begin
        first_c = c;
        chk("restart_addr0", bus.ram_addr, 0);
      end
      tick();
    end
    chk("restart_fetched", (first_c >= 0) ? 1 : 0, 1);
    for (int i = 0; i < 16; i++) begin
      rd = 1'b1;
      #1;
      chk($sformatf("restart_pop%0d", i), disp_data, 12'h300 ^ i);
      tick();
    end
    rd = 1'b0;
    chk("restart_ufl", ufl, 0);

    // Asynchronous reset mid-operation
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ram_en", bus.ram_en, 0);
    chk("arst_data", disp_data, 0);
    chk("arst_addr", bus.ram_addr, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("arst_idle", bus.ram_en, 0);
    chk("arst_head", disp_data, 0);

    // Short frame: exactly 8 reads, then refetch from 0 on the next frame
    do_reset();
    for (int f = 0; f < 2; f++) begin
      fs8 = 1'b1;
      tick();
      fs8 = 1'b0;
      nrd = 0;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (bus8.ram_en) begin
          chk($sformatf("fb8_f%0d_addr", f), bus8.ram_addr, nrd);
          nrd++;
        end
      end
      chk($sformatf("fb8_f%0d_reads", f), nrd, 8);
    end
    chk("fb8_head", disp_data8, 12'h000);
    chk("fb8_ufl", ufl8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port 12-bit framebuffer RAM between the display path and a pixel writer (camera or CPU).
- Display side: prefetches pixels in raster order into a small show-ahead FIFO. vga_driver's vga_data is driven from that FIFO, one pop per active pixel.
- Writer side: gets the RAM on cycles the display does not urgently need it.
- Sits between the framebuffer RAM, the pixel-writer logic and vga_driver, in the clk_vga domain.

Parameters:
- ADDR_W, 16: framebuffer word-address width.
- FB_WORDS, 49152: words per frame (256x192 RGB444); fetch stops after FB_WORDS-1.
- DEPTH, 16: display FIFO depth (power of 2).
- LOW_WM, 4: urgent threshold. Display has strict priority while credits < LOW_WM.

Ports:
- clk_vga  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- frame_start  in  1  one-cycle pulse; flushes the display FIFO and restarts fetch at address 0.
- disp_rd  in  1  pops one pixel (one per active pixel).
- disp_data  out  12  FIFO head, show-ahead; 0 when the FIFO is empty.
- underflow_cnt  out  8  saturating count of pops taken while the FIFO was empty.
- wr_valid  in  1  writer request.
- wr_ready  out  1  writer granted this cycle; transfer occurs on wr_valid&&wr_ready.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  12  write pixel.
- ram_en  out  1  RAM access strobe (registered).
- ram_we  out  1  1 = write, 0 = read (registered).
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_wdata  out  12  RAM write data (registered).
- ram_rdata  in  12  read data, valid the cycle after ram_en&&!ram_we.

Behaviour:
- Reset values: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, underflow_cnt=0, FIFO empty (so disp_data=0), fetch_addr=0, fetch state DONE, in-flight=0.
- Fetch state machine:
  - DONE to RUN on frame_start.
  - RUN to DONE when the read of FB_WORDS-1 is issued.
  - No display fetch is issued in DONE.
- Credits = FIFO occupancy + reads in flight (0..2). Credits never exceed DEPTH.
- Per-cycle grant decision (cycle N). At most one RAM access per cycle. Priority order:
  1. frame_start high: no display fetch this cycle.
  2. URGENT: RUN and credits < LOW_WM; display fetch granted, wr_ready=0.
  3. WRITE: otherwise wr_ready=1. If wr_valid, the write is granted.
  4. FETCH: no write and RUN and credits < DEPTH; display fetch granted.
  5. Otherwise idle.
- wr_ready is combinational and does not depend on wr_valid.
- Timing of a granted access:
  - RAM outputs are registered in cycle N+1.
  - Read data returns in N+2 and is pushed into the FIFO that cycle.
  - fetch_addr increments on each fetch grant.
- Fetch latency: first pixel is visible on disp_data 3 cycles after frame_start.
- Pops:
  - disp_rd with a non-empty FIFO pops the head; the next word appears the following cycle.
  - disp_rd with an empty FIFO: disp_data=0 and underflow_cnt increments, saturating at 255.
  - A push and a pop in the same cycle both take effect; occupancy is unchanged.
- frame_start:
  - Empties the FIFO and sets fetch_addr=0, state RUN.
  - Tags reads already in flight as stale; stale returns are discarded, not pushed, and release their credit.
  - A pop in the same cycle is ignored and not counted as underflow.
  - A write granted in the same cycle completes normally.
- frame_start while already RUN restarts the frame exactly as above.
- Writes to any address are honoured, including addresses ≥ FB_WORDS. No read-after-write ordering is guaranteed within a frame.
- Asynchronous reset mid-operation drops all state. A RAM return after reset is ignored.

Decomposition:
- Package vga_fb_pkg: RGB444 width (12), FB_WORDS default, ADDR_W default, and the grant encoding IDLE/FETCH/WRITE.
- One sub-module, fb_disp_fifo: synchronous show-ahead FIFO with DEPTH, push, pop, flush, occupancy, empty outputs. Zero output when empty.

Test Plan:
1. Reset, frame_start, no writer, no pops → ram_addr reads issued 0..15 on consecutive cycles; occupancy reaches 16; no ram_en afterwards; disp_data=0x000 with RAM model data=addr[11:0].
2. RAM model data=addr[11:0]; frame_start; disp_rd every cycle from cycle 20 for 1000 cycles → disp_data sequence 0x000,0x001,…,0x3E7; underflow_cnt=0.
3. As test 2 plus wr_valid held high → wr_ready never high while credits < LOW_WM; every write with wr_valid&&wr_ready appears on ram_we=1 the next cycle with matching addr/data; underflow_cnt=0.
4. disp_rd pulsed 3 times before any frame_start → disp_data=0 each time, underflow_cnt=3. 300 such pops → underflow_cnt=255.
5. frame_start while 2 reads (addr 5, 6) are in flight → their returns are not pushed; first popped word after restart is RAM word 0.
6. FB_WORDS=8 → reads of addresses 0..7 only, then no ram_en until the next frame_start; the next frame_start refetches from address 0.
